// File: rtl/smpc_pad_serializer.sv
// Per-port TH/TR handshake serializer: snapshots a nibble frame on TH/TR=11 and
// plays it back one nibble per valid TR edge, with over-read and stall protection.
module smpc_pad_serializer #(
   parameter int         PORTS    = 2,
   parameter int         MAX_NIB  = 16,
   parameter int         LW       = $clog2(MAX_NIB + 1),
   parameter int         TIMEOUT  = 255,
   parameter logic [3:0] IDLE_NIB = 4'h0
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         SMPC_CE,
   input  logic [7*PORTS-1:0]           PDR_O,
   input  logic [7*PORTS-1:0]           DDR,
   output logic [7*PORTS-1:0]           PDR_I,
   input  logic [PORTS-1:0]             EN,
   input  logic [4*MAX_NIB*PORTS-1:0]   FRAME,
   input  logic [LW*PORTS-1:0]          FRAME_LEN,
   output logic [PORTS-1:0]             BUSY,
   output logic [PORTS-1:0]             DONE
);

   localparam int            IW      = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;
   localparam logic [LW-1:0] MAX_LEN = LW'(MAX_NIB);
   localparam logic [15:0]   TMO     = 16'(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_END} state_t;

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      state_t                   state, state_nx;
      logic [LW-1:0]            idx, idx_nx, idx_inc, len_q, len_in;
      logic [15:0]              timer, timer_nx, timer_inc;
      logic                     tl, tl_nx, done_q, done_nx;
      logic [3:0]               out_q, out_nx;
      logic [MAX_NIB-1:0][3:0]  shadow;
      logic                     th, tr, snap, due, go_idle;
      logic [6:0]               base, pdr_p;
      logic                     busy_p;

      assign th        = PDR_O[7*p+6];
      assign tr        = PDR_O[7*p+5];
      assign snap      = SMPC_CE && th && tr;
      assign len_in    = FRAME_LEN[LW*p +: LW];
      assign idx_inc   = idx + LW'(1);
      assign timer_inc = timer + 16'd1;

      // Shadow copy keeps a read coherent even if the emulator rewrites FRAME mid-transfer.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            shadow <= '0;
            len_q  <= '0;
         end else if (snap) begin
            shadow <= FRAME[4*MAX_NIB*p +: 4*MAX_NIB];
            len_q  <= (len_in > MAX_LEN) ? MAX_LEN : len_in;
         end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            state  <= ST_IDLE;
            idx    <= '0;
            timer  <= '0;
            tl     <= 1'b1;
            out_q  <= IDLE_NIB;
            done_q <= 1'b0;
         end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            timer  <= timer_nx;
            tl     <= tl_nx;
            out_q  <= out_nx;
            done_q <= done_nx;
         end
      end

      // Even nibbles answer TR=1, odd nibbles TR=0; anything else only ages the timer.
      always_comb begin
         state_nx = state;
         idx_nx   = idx;
         timer_nx = timer;
         tl_nx    = tl;
         out_nx   = out_q;
         done_nx  = 1'b0;
         go_idle  = 1'b0;
         due      = !th && (tr == ~idx[0]);
         if (!EN[p] || snap) begin
            go_idle = 1'b1;
         end else if (SMPC_CE) begin
            unique case (state)
               ST_IDLE: begin
                  if (!th && tr) begin
                     tl_nx = 1'b1;
                     if (len_q != '0) begin
                        out_nx = shadow[0];
                        idx_nx = LW'(1);
                        if (len_q == LW'(1)) begin
                           state_nx = ST_END;
                           done_nx  = 1'b1;
                        end else begin
                           state_nx = ST_XFER;
                        end
                     end else begin
                        out_nx = IDLE_NIB;
                     end
                  end
               end
               ST_XFER: begin
                  if (due) begin
                     out_nx   = shadow[idx[IW-1:0]];
                     tl_nx    = ~idx[0];
                     idx_nx   = idx_inc;
                     timer_nx = '0;
                     if (idx_inc == len_q) begin
                        state_nx = ST_END;
                        done_nx  = 1'b1;
                     end
                  end else if (timer_inc == TMO) begin
                     go_idle = 1'b1;
                  end else begin
                     timer_nx = timer_inc;
                  end
               end
               ST_END: begin
                  if (!th && (tr != tl)) begin
                     tl_nx    = tr;
                     out_nx   = IDLE_NIB;
                     timer_nx = '0;
                  end else if (timer_inc == TMO) begin
                     go_idle = 1'b1;
                  end else begin
                     timer_nx = timer_inc;
                  end
               end
               default: go_idle = 1'b1;
            endcase
         end
         if (go_idle) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
            timer_nx = '0;
            tl_nx    = 1'b1;
            out_nx   = IDLE_NIB;
            done_nx  = 1'b0;
         end
      end

      always_comb begin
         base  = (PDR_O[7*p +: 7] & DDR[7*p +: 7]) | ~DDR[7*p +: 7];
         pdr_p = base;
         if (EN[p]) pdr_p[4:0] = {tl, out_q};
         busy_p = (state != ST_IDLE);
      end

      assign PDR_I[7*p +: 7] = pdr_p;
      assign BUSY[p]         = busy_p;
      assign DONE[p]         = done_q;
   end

endmodule

// File: tb/tb_smpc_pad_serializer.sv
// Directed + randomized bench for smpc_pad_serializer; port 0 serializes, port 1 stays passthrough.
module tb_smpc_pad_serializer;

   localparam int         PORTS    = 2;
   localparam int         MAX_NIB  = 16;
   localparam int         LW       = 5;
   localparam int         TIMEOUT  = 4;
   localparam logic [3:0] IDLE_NIB = 4'hA;

   logic                        CLK = 1'b0;
   logic                        RST_N;
   logic                        SMPC_CE;
   logic [7*PORTS-1:0]          PDR_O, DDR, PDR_I;
   logic [PORTS-1:0]            EN, BUSY, DONE;
   logic [4*MAX_NIB*PORTS-1:0]  FRAME;
   logic [LW*PORTS-1:0]         FRAME_LEN;

   int         total = 0;
   int         bad = 0;
   int         doneSeen = 0;
   logic [3:0] fr  [MAX_NIB];
   logic [3:0] frA [MAX_NIB];

   always #5 CLK = ~CLK;

   smpc_pad_serializer #(
      .PORTS(PORTS), .MAX_NIB(MAX_NIB), .LW(LW), .TIMEOUT(TIMEOUT), .IDLE_NIB(IDLE_NIB)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .SMPC_CE(SMPC_CE), .PDR_O(PDR_O), .DDR(DDR),
      .PDR_I(PDR_I), .EN(EN), .FRAME(FRAME), .FRAME_LEN(FRAME_LEN),
      .BUSY(BUSY), .DONE(DONE)
   );

   // Expected nibble for the i-th toggle of a transfer: frame data, then idle fill.
   function automatic logic [3:0] refNib(input int i, input int len);
      return (i < len) ? fr[i] : IDLE_NIB;
   endfunction

   function automatic int clampLen(input int raw);
      return (raw > MAX_NIB) ? MAX_NIB : raw;
   endfunction

   task automatic loadFrame(input int len);
      for (int k = 0; k < MAX_NIB; k++) FRAME[4*k +: 4] = fr[k];
      FRAME_LEN[LW-1:0] = LW'(len);
   endtask

   task automatic randFrame();
      for (int k = 0; k < MAX_NIB; k++) fr[k] = 4'($urandom);
   endtask

   task automatic applyStimulus(input logic th, input logic tr);
      @(negedge CLK);
      PDR_O[6:5] = {th, tr};
      SMPC_CE    = 1'b1;
      @(negedge CLK);
      SMPC_CE    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [6:0] expPdr,
                              input logic expBusy, input logic expDone);
      total++;
      assert (PDR_I[6:0] === expPdr) else begin
         bad++;
         $error("FAIL %s pdr_i: observed=%h expected=%h", tag, PDR_I[6:0], expPdr);
      end
      total++;
      assert (BUSY[0] === expBusy) else begin
         bad++;
         $error("FAIL %s busy: observed=%b expected=%b", tag, BUSY[0], expBusy);
      end
      total++;
      assert (DONE[0] === expDone) else begin
         bad++;
         $error("FAIL %s done: observed=%b expected=%b", tag, DONE[0], expDone);
      end
      total++;
      assert ({PDR_I[13:7], BUSY[1], DONE[1]} === {7'h5F, 2'b00}) else begin
         bad++;
         $error("FAIL %s port1: observed=%h/%b/%b expected=5f/0/0", tag, PDR_I[13:7], BUSY[1], DONE[1]);
      end
      if (DONE[0] === 1'b1) doneSeen++;
   endtask

   // Snapshot with 11, then `toggles` alternating 01/00 steps; len is the clamped length.
   task automatic runTransfer(input string tag, input int len, input int toggles);
      logic tr;
      logic expTl;
      int   expDone;
      doneSeen = 0;
      applyStimulus(1'b1, 1'b1);
      checkOutput({tag, "-snap"}, {3'b111, IDLE_NIB}, 1'b0, 1'b0);
      for (int i = 0; i < toggles; i++) begin
         tr    = (i % 2 == 0);
         expTl = (len == 0) ? 1'b1 : tr;
         applyStimulus(1'b0, tr);
         checkOutput($sformatf("%s-%0d", tag, i), {1'b0, tr, expTl, refNib(i, len)},
                     (len > 0), (i == len - 1));
      end
      expDone = (len > 0 && toggles >= len) ? 1 : 0;
      total++;
      assert (doneSeen === expDone) else begin
         bad++;
         $error("FAIL %s done-count: observed=%0d expected=%0d", tag, doneSeen, expDone);
      end
   endtask

   initial begin
      int raw;
      RST_N     = 1'b0;
      SMPC_CE   = 1'b0;
      EN        = 2'b01;
      DDR       = {7'h60, 7'h60};
      PDR_O     = {7'h55, 7'h60};
      FRAME     = '0;
      FRAME_LEN = '0;
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("reset", {3'b111, IDLE_NIB}, 1'b0, 1'b0);
      RST_N = 1'b1;

      // Mouse frame
      fr[0] = 4'hB; fr[1] = 4'hF; fr[2] = 4'hF; fr[3] = 4'h0; fr[4] = 4'h8;
      fr[5] = 4'h1; fr[6] = 4'h2; fr[7] = 4'h3; fr[8] = 4'h4; fr[9] = 4'h5;
      for (int k = 10; k < MAX_NIB; k++) fr[k] = 4'($urandom);
      loadFrame(10);
      runTransfer("mouse", 10, 10);

      // Over-read past a short frame
      randFrame();
      loadFrame(3);
      runTransfer("over", 3, 6);

      // Length above MAX_NIB is clamped
      randFrame();
      loadFrame(20);
      runTransfer("clamp", 16, 18);

      // No device present
      randFrame();
      loadFrame(0);
      runTransfer("len0", 0, 3);

      for (int t = 0; t < 4; t++) begin
         randFrame();
         raw = int'($urandom_range(0, 31));
         loadFrame(raw);
         runTransfer($sformatf("rand%0d", t), clampLen(raw), clampLen(raw) + 2);
      end

      // Coherence: FRAME rewritten after TH falls, plus an ignored 10 level
      randFrame();
      for (int k = 0; k < MAX_NIB; k++) frA[k] = fr[k];
      loadFrame(8);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("coh-0", {3'b011, frA[0]}, 1'b1, 1'b0);
      for (int k = 0; k < MAX_NIB; k++) fr[k] = ~frA[k];
      loadFrame(3);
      applyStimulus(1'b0, 1'b0);
      checkOutput("coh-1", {3'b000, frA[1]}, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("coh-10", {3'b100, frA[1]}, 1'b1, 1'b0);
      for (int i = 2; i < 8; i++) begin
         applyStimulus(1'b0, (i % 2 == 0));
         checkOutput($sformatf("coh-%0d", i), {1'b0, (i % 2 == 0), (i % 2 == 0), frA[i]},
                     1'b1, (i == 7));
      end
      runTransfer("coh-new", 3, 4);

      // Timeout after two nibbles
      randFrame();
      loadFrame(6);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("tmo-n0", {3'b011, fr[0]}, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("tmo-n1", {3'b000, fr[1]}, 1'b1, 1'b0);
      for (int j = 1; j < TIMEOUT; j++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput($sformatf("tmo-wait%0d", j), {3'b000, fr[1]}, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("tmo-fire", {3'b001, IDLE_NIB}, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("tmo-restart", {3'b011, fr[0]}, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("tmo-restart1", {3'b000, fr[1]}, 1'b1, 1'b0);

      // EN falls mid-transfer
      randFrame();
      loadFrame(5);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("en-n1", {3'b000, fr[1]}, 1'b1, 1'b0);
      EN[0] = 1'b0;
      @(negedge CLK);
      checkOutput("en-off", {2'b00, 5'h1F}, 1'b0, 1'b0);
      EN[0] = 1'b1;
      @(negedge CLK);
      checkOutput("en-on", {3'b001, IDLE_NIB}, 1'b0, 1'b0);

      // Asynchronous reset mid-transfer clears the shadow too
      randFrame();
      loadFrame(7);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rst-n1", {3'b000, fr[1]}, 1'b1, 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      checkOutput("rst-async", {3'b001, IDLE_NIB}, 1'b0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("rst-noshadow", {3'b011, IDLE_NIB}, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rst-resnap", {3'b011, fr[0]}, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
